// File: rtl/benes_config_sequencer.sv
// Sequencer that steps an external Benes network through a table of switch settings, one per vector.
// Optional run-cycle counter on n_c when BCS_CYCLE_COUNT_EN is defined (n_c tied to 0 otherwise).
module benes_config_sequencer #(
  parameter int N     = 32,
  parameter int P     = 32,
  parameter int SW    = 9,
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int LAT   = 13
) (
  input  logic             clk_sig,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [SW-1:0]    cfg_wdata,
  input  logic             start,
  input  logic [AW:0]      num_steps,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [P*N-1:0]   in_data,
  output logic [P*N-1:0]   net_x,
  output logic [SW-1:0]    net_s,
  input  logic [P*N-1:0]   net_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [P*N-1:0]   out_data,
  output logic [31:0]      n_c
);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, EMIT, DONE} state_e;

  state_e          state_q, state_d;
  logic [AW:0]     num_steps_q, num_steps_d;
  logic [AW:0]     step_q, step_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            out_valid_q, out_valid_d;
  logic [P*N-1:0]  net_x_q, net_x_d;
  logic [P*N-1:0]  out_data_q, out_data_d;
  logic [SW-1:0]   net_s_q, net_s_d;
  logic [SW-1:0]   tbl_q [DEPTH];

  logic start_acc;
  logic in_fire;
  logic out_fire;
  logic last_step;
  logic tbl_we;

  assign start_acc = (state_q == IDLE) && start;
  assign in_fire   = (state_q == LOAD) && in_valid;
  assign out_fire  = out_valid_q && out_ready;
  assign last_step = (step_q == num_steps_q - (AW+1)'(1));
  assign tbl_we    = cfg_we && (state_q == IDLE);

  always_ff @(posedge clk_sig or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (num_steps == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q <= 8'd1) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_fire) begin
          state_d = last_step ? DONE : LOAD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // in_ready depends on state alone so the upstream handshake has no combinational loop through us
  always_comb begin
    busy     = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      LOAD: begin
        busy     = 1'b1;
        in_ready = 1'b1;
      end
      SETTLE, EMIT: begin
        busy = 1'b1;
      end
      default: begin
        busy     = 1'b0;
        in_ready = 1'b0;
      end
    endcase
  end

  always_comb begin
    num_steps_d = num_steps_q;
    step_d      = step_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    out_valid_d = out_valid_q;
    net_x_d     = net_x_q;
    net_s_d     = net_s_q;
    out_data_d  = out_data_q;

    if (start_acc) begin
      num_steps_d = num_steps;
      step_d      = '0;
      done_d      = 1'b0;
    end

    if (in_fire) begin
      net_x_d = in_data;
      net_s_d = tbl_q[step_q[AW-1:0]];
      cnt_d   = 8'(LAT);
    end

    // The network output is sampled in the last settle cycle, so out_valid rises with EMIT
    if (state_q == SETTLE) begin
      if (cnt_q != 8'd0) begin
        cnt_d = cnt_q - 8'd1;
      end
      if (cnt_q <= 8'd1) begin
        out_data_d  = net_y;
        out_valid_d = 1'b1;
      end
    end

    if (out_fire) begin
      out_valid_d = 1'b0;
      step_d      = step_q + (AW+1)'(1);
    end

    if (state_q == DONE) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sig or negedge rst_n) begin
    if (!rst_n) begin
      num_steps_q <= '0;
      step_q      <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      net_x_q     <= '0;
      net_s_q     <= '0;
      out_data_q  <= '0;
    end else begin
      num_steps_q <= num_steps_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      net_x_q     <= net_x_d;
      net_s_q     <= net_s_d;
      out_data_q  <= out_data_d;
    end
  end

  // Switch table is plain storage without reset; its contents are undefined until written
  always_ff @(posedge clk_sig) begin
    if (tbl_we) begin
      tbl_q[cfg_addr] <= cfg_wdata;
    end
  end

  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign net_x     = net_x_q;
  assign net_s     = net_s_q;
  assign out_data  = out_data_q;

`ifdef BCS_CYCLE_COUNT_EN
  logic [31:0] n_c_q, n_c_d;

  // Counts busy cycles plus the DONE cycle, saturating, and holds after the run ends
  always_comb begin
    n_c_d = n_c_q;
    if (start_acc) begin
      n_c_d = '0;
    end else if ((busy || (state_q == DONE)) && (n_c_q != 32'hFFFF_FFFF)) begin
      n_c_d = n_c_q + 32'd1;
    end
  end

  always_ff @(posedge clk_sig or negedge rst_n) begin
    if (!rst_n) begin
      n_c_q <= '0;
    end else begin
      n_c_q <= n_c_d;
    end
  end

  assign n_c = n_c_q;
`else
  assign n_c = '0;
`endif

endmodule

// File: tb/tb_benes_config_sequencer.sv
// Self-checking bench for benes_config_sequencer with P=4, N=8, LAT=3 and a behavioural network model.
// Expected n_c follows BCS_CYCLE_COUNT_EN (0 when the counter is compiled out).
module tb_benes_config_sequencer;

  localparam int N     = 8;
  localparam int P     = 4;
  localparam int SW    = 9;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int LAT   = 3;

`ifdef BCS_CYCLE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_we = 1'b0;
  logic [AW-1:0]    cfg_addr = '0;
  logic [SW-1:0]    cfg_wdata = '0;
  logic             start = 1'b0;
  logic [AW:0]      num_steps = '0;
  logic             busy;
  logic             done;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [P*N-1:0]   in_data = '0;
  logic [P*N-1:0]   net_x;
  logic [SW-1:0]    net_s;
  logic [P*N-1:0]   net_y;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [P*N-1:0]   out_data;
  logic [31:0]      n_c;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  logic [SW-1:0] shadow [DEPTH];

  typedef struct {
    logic [31:0] din;
    logic [8:0]  sel;
    logic [31:0] dout;
  } vec_t;
  vec_t vecs [5];

  benes_config_sequencer #(
    .N(N), .P(P), .SW(SW), .DEPTH(DEPTH), .AW(AW), .LAT(LAT)
  ) dut (
    .clk_sig(clk),
    .rst_n(rst_n),
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata),
    .start(start),
    .num_steps(num_steps),
    .busy(busy),
    .done(done),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .net_x(net_x),
    .net_s(net_s),
    .net_y(net_y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .n_c(n_c)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output lane k takes input lane given by the 2-bit field s[2k+1:2k]
  function automatic logic [31:0] perm(input logic [31:0] x, input logic [8:0] s);
    logic [31:0] y;
    int src;
    y = '0;
    for (int k = 0; k < 4; k++) begin
      src = (int'(s) >> (2 * k)) & 3;
      y[k*8 +: 8] = x[src*8 +: 8];
    end
    return y;
  endfunction

  // Network model: combinational permutation followed by LAT-1 cycles of delay
  logic [31:0] pipe1 = '0;
  logic [31:0] pipe2 = '0;
  always @(posedge clk) begin
    pipe1 <= perm(net_x, net_s);
    pipe2 <= pipe1;
  end
  assign net_y = pipe2;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if (in_ready && out_valid) begin
        bad++;
        $display("[TB] FAIL ready_valid_exclusive: got in_ready=1 out_valid=1, want not both");
      end
    end
  end

  task automatic writeTable(input int a, input logic [SW-1:0] d);
    cfg_we = 1'b1;
    cfg_addr = AW'(a);
    cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic startRun(input int n);
    start = 1'b1;
    num_steps = (AW+1)'(n);
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic applyStimulus(input logic [31:0] v, input int gap);
    bit ok;
    ok = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data = v;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) checkOutput("in_handshake_timeout", 0, 1);
  endtask

  task automatic getOutput(input logic [31:0] exp, input int stall, input string name);
    bit ok;
    ok = 1'b0;
    out_ready = (stall == 0);
    for (int i = 0; i < 100 && !ok; i++) begin
      if (out_valid) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      checkOutput({name, "_timeout"}, 0, 1);
    end else begin
      for (int i = 0; i < stall; i++) begin
        checkOutput({name, "_held"}, out_data, exp);
        @(negedge clk);
      end
      checkOutput(name, out_data, exp);
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic waitDone();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (done) begin
        ok = 1'b1;
        done_cyc = cyc;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) checkOutput("done_timeout", 0, 1);
  endtask

  initial begin
    int n;
    logic [31:0] v;

    vecs[0] = '{32'h44332211, 9'h0E4, 32'h44332211};
    vecs[1] = '{32'h44332211, 9'h01B, 32'h11223344};
    vecs[2] = '{32'hDDCCBBAA, 9'h139, 32'hAADDCCBB};
    vecs[3] = '{32'h12345678, 9'h0AA, 32'h34343434};
    vecs[4] = '{32'hCAFEBABE, 9'h1B1, 32'hFECABEBA};

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_net_x", net_x, 0);
    checkOutput("rst_net_s", net_s, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_n_c", n_c, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Identity then reverse, two-step run
    writeTable(0, 9'h0E4); shadow[0] = 9'h0E4;
    writeTable(1, 9'h01B); shadow[1] = 9'h01B;
    startRun(2);
    checkOutput("start_busy", busy, 1);
    checkOutput("start_in_ready", in_ready, 1);
    checkOutput("start_done_cleared", done, 0);
    applyStimulus(32'h04030201, 0);
    checkOutput("t1_net_x", net_x, 32'h04030201);
    checkOutput("t1_net_s0", net_s, 9'h0E4);
    getOutput(32'h04030201, 0, "t1_out0");
    applyStimulus(32'h04030201, 0);
    checkOutput("t1_net_s1", net_s, 9'h01B);
    getOutput(32'h01020304, 0, "t1_out1");
    waitDone();
    checkOutput("t1_done", done, 1);
    checkOutput("t1_busy", busy, 0);
    checkOutput("t1_run_cycles", done_cyc - start_cyc, 11);
    checkOutput("t1_n_c", n_c, CNT_EN ? 32'd11 : 32'd0);
    @(negedge clk);
    checkOutput("t1_done_level", done, 1);
    checkOutput("t1_net_x_hold", net_x, 32'h04030201);
    checkOutput("t1_net_s_hold", net_s, 9'h01B);

    // Table-driven five-step run with mixed output stalls
    for (int i = 0; i < 5; i++) begin
      writeTable(i, vecs[i].sel);
      shadow[i] = vecs[i].sel;
    end
    startRun(5);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].din, i % 2);
      checkOutput("vec_net_s", net_s, vecs[i].sel);
      getOutput(vecs[i].dout, i % 3, "vec_out");
    end
    waitDone();
    checkOutput("vec_done", done, 1);

    // Zero-step run: never busy, done two cycles after start
    startRun(0);
    checkOutput("z_busy_t1", busy, 0);
    checkOutput("z_done_t1", done, 0);
    @(negedge clk);
    checkOutput("z_done_t2", done, 1);
    checkOutput("z_busy_t2", busy, 0);
    checkOutput("z_out_valid", out_valid, 0);
    checkOutput("z_n_c", n_c, CNT_EN ? 32'd1 : 32'd0);

    // Backpressure in EMIT for five cycles
    writeTable(0, 9'h0E4); shadow[0] = 9'h0E4;
    startRun(1);
    applyStimulus(32'h5A6B7C8D, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_out_data", out_data, 32'h5A6B7C8D);
      checkOutput("bp_out_valid", out_valid, 1);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_n_c", n_c, CNT_EN ? 32'(cyc - start_cyc) : 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    waitDone();
    checkOutput("bp_n_c_total", n_c, CNT_EN ? 32'd11 : 32'd0);

    // Table write while busy is ignored
    writeTable(1, 9'h01B); shadow[1] = 9'h01B;
    startRun(2);
    writeTable(1, 9'h0E4);
    applyStimulus(32'h11111111, 0);
    getOutput(perm(32'h11111111, shadow[0]), 0, "wb_out0");
    applyStimulus(32'hA1B2C3D4, 0);
    checkOutput("wb_net_s", net_s, 9'h01B);
    getOutput(32'hD4C3B2A1, 0, "wb_out1");
    waitDone();

    // Write and start in the same idle cycle: the run sees the new entry
    cfg_we = 1'b1; cfg_addr = '0; cfg_wdata = 9'h01B;
    start = 1'b1; num_steps = 4'd1;
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0; start_cyc = cyc;
    shadow[0] = 9'h01B;
    applyStimulus(32'h04030201, 0);
    checkOutput("ws_net_s", net_s, 9'h01B);
    getOutput(32'h01020304, 0, "ws_out");
    waitDone();
    writeTable(0, 9'h0E4); shadow[0] = 9'h0E4;

    // Asynchronous reset during SETTLE of step 1, then a clean restart
    startRun(2);
    applyStimulus(32'h0F0E0D0C, 0);
    getOutput(32'h0F0E0D0C, 0, "ar_out0");
    applyStimulus(32'h99887766, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("ar_busy", busy, 0);
    checkOutput("ar_done", done, 0);
    checkOutput("ar_in_ready", in_ready, 0);
    checkOutput("ar_out_valid", out_valid, 0);
    checkOutput("ar_net_x", net_x, 0);
    checkOutput("ar_net_s", net_s, 0);
    checkOutput("ar_out_data", out_data, 0);
    checkOutput("ar_n_c", n_c, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("ar_no_partial", out_valid, 0);
    startRun(1);
    applyStimulus(32'h55667788, 0);
    getOutput(perm(32'h55667788, shadow[0]), 0, "ar_restart_out");
    waitDone();
    checkOutput("ar_restart_done", done, 1);

    // Start while busy is ignored
    startRun(2);
    start = 1'b1; num_steps = 4'd1;
    @(negedge clk);
    start = 1'b0;
    applyStimulus(32'h01234567, 0);
    getOutput(perm(32'h01234567, shadow[0]), 0, "sb_out0");
    checkOutput("sb_still_busy", busy, 1);
    checkOutput("sb_not_done", done, 0);
    applyStimulus(32'h89ABCDEF, 0);
    getOutput(perm(32'h89ABCDEF, shadow[1]), 0, "sb_out1");
    waitDone();
    checkOutput("sb_done", done, 1);

    // Randomized runs against the permutation model
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < DEPTH; a++) begin
        shadow[a] = SW'($urandom);
        writeTable(a, shadow[a]);
      end
      n = $urandom_range(1, DEPTH);
      startRun(n);
      for (int s = 0; s < n; s++) begin
        v = $urandom;
        applyStimulus(v, $urandom_range(0, 2));
        checkOutput("rnd_net_x", net_x, v);
        checkOutput("rnd_net_s", net_s, shadow[s]);
        getOutput(perm(v, shadow[s]), $urandom_range(0, 3), "rnd_out");
      end
      waitDone();
      checkOutput("rnd_n_c", n_c, CNT_EN ? 32'(done_cyc - start_cyc) : 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
